fetch_queue_unit: RTL and testbench

//  Parametrised instruction-fetch stage: PC generation, a synchronous

---
 rtl/fetch_queue_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - PC generation, imem read port and fetch queue toward decode
module fetch_queue_unit #(
    parameter int                   DataWidth    = 32,
    parameter int                   AddrWidth    = 10,
    parameter int                   FQ_DEPTH     = 4,
    parameter logic [DataWidth-1:0] RESET_VECTOR = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           next_PC_sel,
    input  logic                 Branch,
    input  logic                 flush,
    input  logic [DataWidth-1:0] Branch_target,
    input  logic [DataWidth-1:0] Jal_target,
    input  logic [DataWidth-1:0] Jalr_target,
    output logic                 imem_req,
    output logic [AddrWidth-1:0] imem_addr,
    input  logic [DataWidth-1:0] imem_rdata,
    output logic                 fq_valid,
    input  logic                 fq_ready,
    output logic [DataWidth-1:0] PC_OUT,
    output logic [DataWidth-1:0] Inst_out,
    output logic                 misalign_trap,
    output logic [DataWidth-1:0] misalign_addr
);

    localparam int PtrW = $clog2(FQ_DEPTH);
    localparam int CntW = PtrW + 1;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [DataWidth-1:0] r_pc;
    logic                 r_inflight;
    logic [DataWidth-1:0] r_inflight_pc;
    logic [DataWidth-1:0] r_q_pc   [FQ_DEPTH];
    logic [DataWidth-1:0] r_q_inst [FQ_DEPTH];
    logic [PtrW-1:0]      r_wr_ptr;
    logic [PtrW-1:0]      r_rd_ptr;
    logic [CntW-1:0]      r_count;
    logic                 r_trap;
    logic [DataWidth-1:0] r_trap_addr;

    logic                 w_redirect;
    logic [DataWidth-1:0] w_target;
    logic                 w_misalign;
    logic                 w_kill;
    logic                 w_room;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;

    // Decode the redirect request and pick its target
    always_comb begin
        w_redirect = 1'b0;
        w_target   = Branch_target;
        case (next_PC_sel)
            2'b01: begin
                w_redirect = Branch;
                w_target   = Branch_target;
            end
            2'b10: begin
                w_redirect = 1'b1;
                w_target   = Jal_target;
            end
            2'b11: begin
                w_redirect = 1'b1;
                w_target   = Jalr_target;
            end
            default: begin
                w_redirect = 1'b0;
            end
        endcase
    end

    // Any redirect (aligned or not) or flush throws away queue and in-flight read
    assign w_misalign = w_redirect && (w_target[1:0] != 2'b00);
    assign w_kill     = w_redirect || flush;
    // Queued plus in-flight entries bound the issue rate so a response always has a slot
    assign w_room     = (r_count + CntW'(r_inflight)) < CntW'(FQ_DEPTH);
    assign w_push     = r_inflight && !w_kill;
    assign w_pop      = (r_count != '0) && fq_ready && !w_kill;

    // RUN/HALT state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and issue decision
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_misalign) begin
                    w_state_next = S_HALT;
                end else begin
                    w_issue = !reset && !w_kill && w_room;
                end
            end
            S_HALT: begin
                if (w_redirect && !w_misalign) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    // PC, in-flight tag and trap reporting
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_VECTOR;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_trap        <= 1'b0;
            r_trap_addr   <= '0;
        end else begin
            r_trap <= w_misalign;
            if (w_misalign) begin
                r_trap_addr <= w_target;
            end
            if (w_redirect && !w_misalign) begin
                r_pc <= w_target;
            end else if (w_issue) begin
                r_pc <= r_pc + DataWidth'(4);
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset || w_kill) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
        end
    end

    // Queue storage; contents are meaningless while the count says empty
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_q_pc[r_wr_ptr]   <= r_inflight_pc;
            r_q_inst[r_wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req      = w_issue;
    assign imem_addr     = r_pc[AddrWidth+1:2];
    assign fq_valid      = (r_count != '0);
    assign PC_OUT        = fq_valid ? r_q_pc[r_rd_ptr] : '0;
    assign Inst_out      = fq_valid ? r_q_inst[r_rd_ptr] : '0;
    assign misalign_trap = r_trap;
    assign misalign_addr = r_trap_addr;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard bench for fetch_queue_unit against a queue-based fetch model
module tb_fetch_queue_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clock;
    logic        reset;
    logic [1:0]  next_PC_sel;
    logic        Branch;
    logic        flush;
    logic [31:0] Branch_target;
    logic [31:0] Jal_target;
    logic [31:0] Jalr_target;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        fq_valid;
    logic        fq_ready;
    logic [31:0] PC_OUT;
    logic [31:0] Inst_out;
    logic        misalign_trap;
    logic [31:0] misalign_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: fetch PC, fetch queue, one outstanding read, halt flag
    entry_t      m_q[$];
    entry_t      sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_inf_pc;
    bit          m_inf;
    bit          m_halt;
    bit          m_trap;
    logic [31:0] m_addr;
    bit          m_init = 0;
    bit          tb_kill = 0;

    fetch_queue_unit #(
        .DataWidth   (32),
        .AddrWidth   (10),
        .FQ_DEPTH    (DEPTH),
        .RESET_VECTOR(RV)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .next_PC_sel  (next_PC_sel),
        .Branch       (Branch),
        .flush        (flush),
        .Branch_target(Branch_target),
        .Jal_target   (Jal_target),
        .Jalr_target  (Jalr_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .fq_valid     (fq_valid),
        .fq_ready     (fq_ready),
        .PC_OUT       (PC_OUT),
        .Inst_out     (Inst_out),
        .misalign_trap(misalign_trap),
        .misalign_addr(misalign_addr)
    );

    always #5 clock = ~clock;

    // Synchronous imem: word n holds n; junk when not requested
    always @(posedge clock) begin
        imem_rdata <= imem_req ? {22'd0, imem_addr} : 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {22'd0, pc[11:2]};
    endfunction

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        t = $urandom & 32'h0000_3FFF;
        if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare, then advance the model with the same inputs
    task automatic tick();
        bit          redir;
        bit          mis;
        bit          kill;
        bit          exp_req;
        bit          exp_valid;
        bit          pop;
        logic [31:0] tgt;
        entry_t      e;
        #1;
        redir = 0;
        tgt   = Branch_target;
        case (next_PC_sel)
            2'b01: begin redir = Branch; tgt = Branch_target; end
            2'b10: begin redir = 1;      tgt = Jal_target;    end
            2'b11: begin redir = 1;      tgt = Jalr_target;   end
            default: redir = 0;
        endcase
        mis       = redir && (tgt[1:0] != 2'b00);
        kill      = redir || flush;
        tb_kill   = kill;
        exp_req   = !reset && !m_halt && !kill && ((m_q.size() + int'(m_inf)) < DEPTH);
        exp_valid = (m_q.size() != 0);
        pop       = exp_valid && fq_ready && !kill && !reset;
        if (m_init) begin
            check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            if (exp_req) check("imem_addr", {22'd0, imem_addr}, {22'd0, m_pc[11:2]});
            check("fq_valid", {31'd0, fq_valid}, {31'd0, exp_valid});
            if (!exp_valid) begin
                check("PC_OUT_empty", PC_OUT, 32'd0);
                check("Inst_out_empty", Inst_out, 32'd0);
            end
            check("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_trap});
            check("misalign_addr", misalign_addr, m_addr);
            if (pop) sb.push_back(m_q[0]);
        end
        @(posedge clock);
        if (reset) begin
            m_init = 1;
            m_pc   = RV;
            m_q.delete();
            m_inf  = 0;
            m_halt = 0;
            m_trap = 0;
            m_addr = 0;
        end else if (m_init) begin
            m_trap = mis;
            if (mis) begin
                m_addr = tgt;
                m_halt = 1;
                m_q.delete();
                m_inf  = 0;
            end else if (redir) begin
                m_pc   = tgt;
                m_halt = 0;
                m_q.delete();
                m_inf  = 0;
            end else if (flush) begin
                m_q.delete();
                m_inf = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_inf) begin
                    e.pc   = m_inf_pc;
                    e.inst = inst_of(m_inf_pc);
                    m_q.push_back(e);
                end
                m_inf = exp_req;
                if (exp_req) begin
                    m_inf_pc = m_pc;
                    m_pc     = m_pc + 32'd4;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Monitor: every honoured handshake must match the oldest expected entry
    initial begin
        entry_t e;
        forever begin
            @(negedge clock);
            #2;
            if (m_init && fq_valid === 1'b1 && fq_ready && !reset && !tb_kill) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got PC %h Inst %h expected no entry", PC_OUT, Inst_out);
                end else begin
                    e = sb.pop_front();
                    check("head_pc", PC_OUT, e.pc);
                    check("head_inst", Inst_out, e.inst);
                end
            end
        end
    end

    initial begin
        clock         = 0;
        reset         = 1;
        next_PC_sel   = 2'b00;
        Branch        = 0;
        flush         = 0;
        fq_ready      = 1;
        Branch_target = 0;
        Jal_target    = 0;
        Jalr_target   = 0;
        @(negedge clock);
        run(2);
        reset = 0;
        run(12);
        fq_ready = 0;
        run(10);
        fq_ready = 1;
        run(8);
        fq_ready = 0;
        run(3);
        Jal_target  = 32'h100;
        next_PC_sel = 2'b10;
        tick();
        next_PC_sel = 2'b00;
        fq_ready    = 1;
        run(6);
        Branch_target = 32'h80;
        next_PC_sel   = 2'b01;
        Branch        = 0;
        run(2);
        Branch_target = 32'h40;
        Branch        = 1;
        tick();
        Branch      = 0;
        next_PC_sel = 2'b00;
        run(5);
        Jalr_target = 32'h102;
        next_PC_sel = 2'b11;
        tick();
        next_PC_sel = 2'b00;
        run(3);
        flush = 1;
        tick();
        flush = 0;
        run(3);
        Jal_target  = 32'h200;
        next_PC_sel = 2'b10;
        tick();
        next_PC_sel = 2'b00;
        run(6);
        fq_ready = 0;
        run(6);
        fq_ready = 1;
        run(4);
        reset = 1;
        tick();
        reset = 0;
        run(6);
        fq_ready = 0;
        run(3);
        flush = 1;
        tick();
        flush    = 0;
        fq_ready = 1;
        run(6);
        Jal_target  = 32'hFFFF_FFF8;
        next_PC_sel = 2'b10;
        tick();
        next_PC_sel = 2'b00;
        run(6);
        for (int i = 0; i < 400; i++) begin
            int r;
            r             = $urandom_range(0, 99);
            fq_ready      = ($urandom_range(0, 3) != 0);
            flush         = (r < 4);
            reset         = (r == 99);
            next_PC_sel   = (r >= 4 && r < 14) ? 2'($urandom_range(1, 3)) : 2'b00;
            Branch        = 1'($urandom_range(0, 1));
            Branch_target = rnd_tgt();
            Jal_target    = rnd_tgt();
            Jalr_target   = rnd_tgt();
            tick();
        end
        reset       = 0;
        flush       = 0;
        next_PC_sel = 2'b00;
        run(4);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
